// File: rtl/pooling_unit.sv
// Multi-channel max/average pooling engine: accepts one window of SIZE samples per
// channel, scans it one sample per enabled cycle and presents one result per channel.
module pooling_unit #(
  parameter int IL   = 8,
  parameter int FL   = 12,
  parameter int SIZE = 4,
  parameter int CH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [CH*SIZE*(IL+FL)-1:0] im,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CH*(IL+FL)-1:0]    om,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam int DW = IL + FL;
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int SH = $clog2(SIZE);
  localparam int AW = DW + PW;
  localparam logic [PW-1:0] PTR_LAST = PW'(SIZE - 1);
  // Most negative DW value, sign-extended to accumulator width.
  localparam logic [AW-1:0] ACC_MIN = {{(PW + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic                      mode_q, mode_d;
  logic [CH*SIZE*DW-1:0]     win_q, win_d;
  logic signed [AW-1:0]      acc_q [CH];
  logic signed [AW-1:0]      acc_d [CH];
  logic [CH*DW-1:0]          om_q, om_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [AW-1:0]      acc_upd [CH];
  logic [DW-1:0]             ch_res [CH];

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [DW-1:0]        samp;
    logic signed [AW-1:0] samp_x;

    assign samp   = win_q[(gi*SIZE + int'(ptr_q))*DW +: DW];
    assign samp_x = {{PW{samp[DW-1]}}, samp};
    assign acc_upd[gi] = mode_q ? (acc_q[gi] + samp_x)
                                : ((samp_x > acc_q[gi]) ? samp_x : acc_q[gi]);
    // Taking DW bits starting at SH is the arithmetic shift, i.e. floor division.
    assign ch_res[gi] = mode_q ? acc_upd[gi][SH +: DW] : acc_upd[gi][DW-1:0];
  end

  assign in_ready  = (state_q == IDLE) && en;
  assign out_valid = out_valid_q;
  assign om        = om_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    win_d       = win_q;
    om_d        = om_q;
    out_valid_d = out_valid_q;
    for (int c = 0; c < CH; c++) acc_d[c] = acc_q[c];

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            win_d   = im;
            mode_d  = mode;
            ptr_d   = '0;
            for (int c = 0; c < CH; c++) acc_d[c] = mode ? '0 : ACC_MIN;
            state_d = SCAN;
          end
        end
        SCAN: begin
          for (int c = 0; c < CH; c++) acc_d[c] = acc_upd[c];
          if (ptr_q == PTR_LAST) begin
            for (int c = 0; c < CH; c++) om_d[c*DW +: DW] = ch_res[c];
            ptr_d       = '0;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      mode_q      <= 1'b0;
      win_q       <= '0;
      om_q        <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < CH; c++) acc_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      om_q        <= om_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < CH; c++) acc_q[c] <= acc_d[c];
    end
  end
endmodule

// File: tb/tb_pooling_unit.sv
// Scoreboard bench for pooling_unit: a default 4x4 instance with directed windows
// and an 8-sample, 2-channel instance streaming back-to-back windows.
module tb_pooling_unit;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Default instance: SIZE=4, CH=4, DW=20
  logic         en_a = 1, mode_a = 0, in_valid_a = 0, out_ready_a = 1;
  logic [319:0] im_a = '0;
  logic         in_ready_a, out_valid_a;
  logic [79:0]  om_a;

  pooling_unit dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .im(im_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .om(om_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  // Override instance: SIZE=8, CH=2
  logic         en_b = 1, mode_b = 0, in_valid_b = 0, out_ready_b = 1;
  logic [319:0] im_b = '0;
  logic         in_ready_b, out_valid_b;
  logic [39:0]  om_b;

  pooling_unit #(.IL(8), .FL(12), .SIZE(8), .CH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .im(im_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .om(om_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  logic [79:0] sb_a[$];
  logic [39:0] sb_b[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] row(input logic [19:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  logic [319:0] win_tab [4];
  logic [79:0]  exp_tab [4];
  logic         mode_tab[4];

  // Monitors: pop and compare on each completed output handshake
  always @(negedge clk) begin
    if (rst_n && en_a && out_valid_a && out_ready_a) begin
      assertions++;
      if (sb_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected: got om %h, expected no output", om_a);
      end else begin
        logic [79:0] e;
        e = sb_a.pop_front();
        $display("txn A om=%h exp=%h", om_a, e);
        if (om_a !== e) begin
          failures++;
          $display("FAIL a_om: got %h, expected %h", om_a, e);
        end
      end
    end
  end

  int cyc = 0;
  int last_b = -1;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && en_b && out_valid_b && out_ready_b) begin
      logic [39:0] e;
      if (sb_b.size() == 0) begin
        chk("b_unexpected", 80'(om_b), 80'hDEAD);
      end else begin
        e = sb_b.pop_front();
        $display("txn B om=%h exp=%h cyc=%0d", om_b, e, cyc);
        chk("b_om", 80'(om_b), 80'(e));
      end
      if (last_b >= 0) chk("b_spacing", 80'(cyc - last_b), 80'd10);
      last_b = cyc;
    end
  end

  function automatic logic [39:0] model_b(input logic [319:0] w, input logic m);
    logic [39:0] r;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      int sum, mx, s, res;
      sum = 0;
      mx  = -(1 << 19);
      for (int k = 0; k < 8; k++) begin
        s = int'($signed(w[(c*8 + k)*20 +: 20]));
        sum += s;
        if (s > mx) mx = s;
      end
      res = m ? (sum >>> 3) : mx;
      r[c*20 +: 20] = res[19:0];
    end
    return r;
  endfunction

  task automatic wait_ready_a();
    int n = 0;
    while (!in_ready_a && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready_a) chk("a_ready_timeout", 80'(in_ready_a), 80'd1);
  endtask

  task automatic send_a(input int idx);
    wait_ready_a();
    im_a       = win_tab[idx];
    mode_a     = mode_tab[idx];
    in_valid_a = 1;
    sb_a.push_back(exp_tab[idx]);
    @(posedge clk); #1;
    in_valid_a = 0;
  endtask

  task automatic wait_out_a(output int n);
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1; n++;
      if (out_valid_a) break;
    end
    if (!out_valid_a) chk("a_out_timeout", 80'(out_valid_a), 80'd1);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (out_valid_a && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (out_valid_a) chk("a_idle_timeout", 80'(out_valid_a), 80'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // A: mixed-sign max; B: averages incl. rounding; C: ties/most-negative max; D: more averages
    win_tab[0] = {row(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF),
                  row(20'h01000, 20'h03000, 20'hFE000, 20'h02000),
                  row(20'hFFFFF, 20'hFFFFE, 20'hFFFFD, 20'hFFFFC),
                  row(20'h01000, 20'hFE000, 20'h03800, 20'h00400)};
    mode_tab[0] = 0;
    exp_tab[0]  = {20'h7FFFF, 20'h03000, 20'hFFFFF, 20'h03800};
    win_tab[1] = {row(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF),
                  row(20'h01000, 20'h03000, 20'hFE000, 20'h02000),
                  row(20'hFFFFF, 20'h00000, 20'h00000, 20'h00000),
                  row(20'h00001, 20'h00000, 20'h00000, 20'h00000)};
    mode_tab[1] = 1;
    exp_tab[1]  = {20'h7FFFF, 20'h01000, 20'hFFFFF, 20'h00000};
    win_tab[2] = {row(20'h00000, 20'h00000, 20'h00000, 20'h00000),
                  row(20'hFFFFF, 20'h80000, 20'h80001, 20'hFFFFE),
                  row(20'h00010, 20'h00010, 20'h00005, 20'h00010),
                  row(20'h80000, 20'h80000, 20'h80000, 20'h80000)};
    mode_tab[2] = 0;
    exp_tab[2]  = {20'h00000, 20'hFFFFF, 20'h00010, 20'h80000};
    win_tab[3] = {row(20'h00004, 20'h00004, 20'h00004, 20'h00003),
                  row(20'hFFFFD, 20'h00000, 20'h00000, 20'h00000),
                  row(20'h00003, 20'h00000, 20'h00000, 20'h00000),
                  row(20'h80000, 20'h80000, 20'h80000, 20'h80000)};
    mode_tab[3] = 1;
    exp_tab[3]  = {20'h00003, 20'hFFFFF, 20'h00000, 20'h80000};

    // Reset state
    #12;
    chk("rst_out_valid", 80'(out_valid_a), 80'd0);
    chk("rst_om", om_a, 80'd0);
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    chk("rst_in_ready", 80'(in_ready_a), 80'd1);

    // Directed windows, latency SIZE edges after accept
    send_a(0);
    wait_out_a(lat);
    chk("latency_a", 80'(lat), 80'd4);
    wait_idle_a();
    for (int i = 1; i < 4; i++) begin
      send_a(i);
      wait_out_a(lat);
      wait_idle_a();
    end

    // Backpressure: HOLD for 5 cycles with a competing window offered
    out_ready_a = 0;
    send_a(2);
    wait_out_a(lat);
    im_a = win_tab[3];
    mode_a = 1;
    in_valid_a = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_om", om_a, exp_tab[2]);
      chk("bp_out_valid", 80'(out_valid_a), 80'd1);
      chk("bp_in_ready", 80'(in_ready_a), 80'd0);
      @(posedge clk); #1;
    end
    sb_a.push_back(exp_tab[3]);
    out_ready_a = 1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 80'(in_ready_a), 80'd1);
    chk("bp_idle_valid", 80'(out_valid_a), 80'd0);
    @(posedge clk); #1;
    in_valid_a = 0;
    chk("bp_accepted", 80'(in_ready_a), 80'd0);
    wait_out_a(lat);
    chk("bp_latency", 80'(lat), 80'd4);
    wait_idle_a();

    // Enable freeze for 3 edges mid-SCAN
    send_a(0);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); lat++; #1;
      if (lat == 1) en_a = 0;
      if (lat >= 2 && lat <= 4) chk("freeze_valid", 80'(out_valid_a), 80'd0);
      if (lat == 4) en_a = 1;
      if (out_valid_a) break;
    end
    chk("freeze_latency", 80'(lat), 80'd7);
    wait_idle_a();

    // Async reset mid-SCAN discards the window
    wait_ready_a();
    im_a = win_tab[1];
    mode_a = 1;
    in_valid_a = 1;
    @(posedge clk); #1;
    in_valid_a = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("arst_out_valid", 80'(out_valid_a), 80'd0);
    chk("arst_om", om_a, 80'd0);
    @(posedge clk); #2;
    rst_n = 1;
    #1;
    chk("arst_in_ready", 80'(in_ready_a), 80'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("arst_no_output", 80'(out_valid_a), 80'd0);
    end

    // Back-to-back windows on the SIZE=8, CH=2 instance
    in_valid_b = 1;
    for (int w = 0; w < 5; w++) begin
      int n;
      logic [319:0] v;
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 8; k++)
          v[(c*8 + k)*20 +: 20] = 20'((w*131 + c*977 + k*7919 + 5) * 613);
      im_b = v;
      mode_b = w[0];
      sb_b.push_back(model_b(v, w[0]));
      n = 0;
      while (!in_ready_b && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (!in_ready_b) chk("b_ready_timeout", 80'(in_ready_b), 80'd1);
      @(posedge clk); #1;
    end
    in_valid_b = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
    end

    chk("a_queue_empty", 80'(sb_a.size()), 80'd0);
    chk("b_queue_empty", 80'(sb_b.size()), 80'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/pooling_unit.md
Name: pooling_unit

Overview:
Parametrised multi-channel pooling engine for the fixed-point datapath; reduces one window of SIZE samples per channel to one result per channel, selectable max or average.
- Samples are signed two's-complement fixed point (IL integer, FL fraction bits).
- Sits between the convolution output buffer and the next layer's input stage.
- Valid/ready handshakes on both sides; `en` freezes the block for layer-level stalls.

Parameters:
- IL, 8, integer bits incl. sign
- FL, 12, fraction bits; DW = IL+FL
- SIZE, 4, samples per window; power of two, >= 1
- CH, 4, channels processed in parallel
- PW, max(1,$clog2(SIZE)), pointer width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable; 0 freezes all state, outputs hold
- mode  in  1  0 = max, 1 = average; sampled at accept
- im  in  CH*SIZE*DW  window; channel c sample k at bits [(c*SIZE+k)*DW +: DW]
- in_valid  in  1  im/mode valid
- in_ready  out  1  block can accept a window
- om  out  CH*DW  results; channel c at [c*DW +: DW]
- out_valid  out  1  om valid
- out_ready  in  1  downstream accepts om

Behaviour:
- Reset (async, rst_n=0): state IDLE, pointer 0, accumulators 0, om 0, out_valid 0; in_ready=1 once rst_n=1. Reset mid-SCAN or mid-HOLD discards the window; no partial om is ever presented.
- in_ready = (state==IDLE) && en (combinational). out_valid = (state==HOLD), registered.
- FSM, all transitions gated by en=1; with en=0 nothing changes, in_valid is ignored, om/out_valid hold:
  - IDLE: on in_valid && in_ready, latch im and mode, pointer<=0, acc[c]<=most-negative DW value (max) or 0 (avg); go to SCAN.
  - SCAN: each cycle process sample im[c][pointer] for every channel; pointer++. The cycle with pointer==SIZE-1 writes the final om, goes to HOLD, and wraps pointer to 0.
  - HOLD: om stable. On out_valid && out_ready go to IDLE. in_ready stays 0 in HOLD; no same-cycle accept.
- Latency: out_valid rises exactly SIZE enabled edges after the accept edge.
- Throughput: SIZE+2 cycles per window with out_ready tied high.
- Max mode: signed compare; acc[c] <= (s > acc[c]) ? s : acc[c]. On ties acc keeps its value. om[c] = acc.
- Average mode:
  - acc[c] is DW+PW bits signed; add sign-extended samples. No overflow is possible.
  - om[c] = (acc >>> $clog2(SIZE)) truncated to DW bits, i.e. floor rounding toward minus infinity.
  - SIZE=1 gives om = the sample.
- Mode and window are latched at accept; changes to im/mode during SCAN/HOLD have no effect.
- Channels are independent; identical control, no cross-channel interaction.

Test Plan:
1. Defaults, mode=0, channel 0 = {1.0=0x01000, -2.0=0xFE000, 3.5=0x03800, 0.25=0x00400} -> om[0]=0x03800; out_valid rises 4 edges after accept.
2. mode=0, channel 1 all negative {0xFFFFF, 0xFFFFE, 0xFFFFD, 0xFFFFC} -> om[1]=0xFFFFF (-1 LSB), not 0. mode=1, channel 2 = {0x01000, 0x03000, 0xFE000, 0x02000} -> om[2]=0x01000.
3. Average rounding: {0x00001, 0, 0, 0} -> 0x00000. {0xFFFFF, 0, 0, 0} -> 0xFFFFF. Max positive {0x7FFFF x4} -> 0x7FFFF, no overflow.
4. Backpressure: hold out_ready=0 for 5 cycles in HOLD -> om and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next edge, next window accepted the edge after.
5. en=0 for 3 cycles mid-SCAN -> pointer and acc frozen; final om unchanged and out_valid delayed by exactly 3 cycles. Then assert rst_n=0 mid-SCAN -> out_valid=0 and om=0 immediately (async); after release, in_ready=1.
6. Back-to-back windows with out_ready=1 and SIZE=8, CH=2 override -> one result every 10 cycles, each om matching a reference model.
